// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake states, the memory word and the arbiter FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

  localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/ram_arbiter.sv
// Shares the single-port unified RAM between instruction fetch and data (LW/SW) ports.
// Data wins by default; a starvation counter forces an instruction grant.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  ramstate_t         ramstate
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             dreq;

  assign dreq = dREN | dWEN;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    iload        = '0;
    dload        = '0;
    iwait        = iREN;
    dwait        = dreq;

    unique case (state_q)
      IDLE: begin
        if (dreq && !(iREN && starve_cnt_q == CNT_MAX)) begin
          state_d = DGNT;
          if (!iREN)
            starve_cnt_d = '0;
          else if (starve_cnt_q < CNT_MAX)
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end else if (iREN) begin
          state_d      = IGNT;
          starve_cnt_d = '0;
        end
      end

      IGNT: begin
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ramstate == ACCESS) begin
            iwait   = 1'b0;
            iload   = ramload;
            state_d = IDLE;
          end
        end
      end

      DGNT: begin
        if (!dreq) begin
          state_d = IDLE;
        end else begin
          ramaddr = daddr;
          // A simultaneous dREN/dWEN is a store; only plain loads return data.
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          if (ramstate == ACCESS) begin
            dwait   = 1'b0;
            dload   = dWEN ? '0 : ramload;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed, table-driven bench for ram_arbiter with hand sequences for starvation.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
  ramstate_t   ramstate;

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        nrst, iren, dren, dwen;
    logic [31:0] iaddr, daddr, dstore, ramload;
    ramstate_t   rs;
    logic        e_iwait, e_dwait, e_ramren, e_ramwen;
    logic [31:0] e_ramaddr, e_ramstore, e_iload, e_dload;
    arb_state_t  e_state;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic nrst_i, input logic iren_i, input logic dren_i,
                               input logic dwen_i, input logic [31:0] ia, input logic [31:0] da,
                               input logic [31:0] ds, input logic [31:0] rl, input ramstate_t rs);
    nRST     = nrst_i;
    iREN     = iren_i;
    dREN     = dren_i;
    dWEN     = dwen_i;
    iaddr    = ia;
    daddr    = da;
    dstore   = ds;
    ramload  = rl;
    ramstate = rs;
  endtask

  initial begin
    // Reset and conflicts: nRST, iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    // then expected iwait, dwait, ramREN, ramWEN, ramaddr, ramstore, iload, dload, state.
    vecs.push_back('{0,1,0,1, 32'h0,  32'h100,32'hDEADBEEF,32'h0,       FREE,   1,1,0,0, 32'h0,  32'h0,       32'h0,       32'h0,       IDLE});
    vecs.push_back('{1,1,0,0, 32'h40, 32'h0,  32'h0,       32'h0,       FREE,   1,0,0,0, 32'h0,  32'h0,       32'h0,       32'h0,       IDLE});
    vecs.push_back('{1,1,0,0, 32'h40, 32'h0,  32'h0,       32'h8C220004,ACCESS, 0,0,1,0, 32'h40, 32'h0,       32'h8C220004,32'h0,       IGNT});
    vecs.push_back('{1,0,0,0, 32'h0,  32'h0,  32'h0,       32'h0,       FREE,   0,0,0,0, 32'h0,  32'h0,       32'h0,       32'h0,       IDLE});
    vecs.push_back('{1,1,0,1, 32'h44, 32'h100,32'hDEADBEEF,32'h0,       FREE,   1,1,0,0, 32'h0,  32'h0,       32'h0,       32'h0,       IDLE});
    vecs.push_back('{1,1,0,1, 32'h44, 32'h100,32'hDEADBEEF,32'h12345678,ACCESS, 1,0,0,1, 32'h100,32'hDEADBEEF,32'h0,       32'h0,       DGNT});
    vecs.push_back('{1,1,0,0, 32'h44, 32'h0,  32'h0,       32'h0,       FREE,   1,0,0,0, 32'h0,  32'h0,       32'h0,       32'h0,       IDLE});
    vecs.push_back('{1,1,0,0, 32'h44, 32'h0,  32'h0,       32'hAAAA0001,ACCESS, 0,0,1,0, 32'h44, 32'h0,       32'hAAAA0001,32'h0,       IGNT});
    // Slow RAM: three BUSY, one ERROR, then ACCESS.
    vecs.push_back('{1,0,1,0, 32'h0,  32'h200,32'h0,       32'h0,       FREE,   0,1,0,0, 32'h0,  32'h0,       32'h0,       32'h0,       IDLE});
    vecs.push_back('{1,0,1,0, 32'h0,  32'h200,32'h0,       32'h55,      BUSY,   0,1,1,0, 32'h200,32'h0,       32'h0,       32'h0,       DGNT});
    vecs.push_back('{1,0,1,0, 32'h0,  32'h200,32'h0,       32'h55,      BUSY,   0,1,1,0, 32'h200,32'h0,       32'h0,       32'h0,       DGNT});
    vecs.push_back('{1,0,1,0, 32'h0,  32'h200,32'h0,       32'h55,      BUSY,   0,1,1,0, 32'h200,32'h0,       32'h0,       32'h0,       DGNT});
    vecs.push_back('{1,0,1,0, 32'h0,  32'h200,32'h0,       32'h66,      ERROR,  0,1,1,0, 32'h200,32'h0,       32'h0,       32'h0,       DGNT});
    vecs.push_back('{1,0,1,0, 32'h0,  32'h200,32'h0,       32'hCAFEF00D,ACCESS, 0,0,1,0, 32'h200,32'h0,       32'h0,       32'hCAFEF00D,DGNT});
    vecs.push_back('{1,0,0,0, 32'h0,  32'h0,  32'h0,       32'h0,       FREE,   0,0,0,0, 32'h0,  32'h0,       32'h0,       32'h0,       IDLE});
    // Aborts: iREN withdrawn mid-IGNT, reset mid-DGNT.
    vecs.push_back('{1,1,0,0, 32'h80, 32'h0,  32'h0,       32'h0,       FREE,   1,0,0,0, 32'h0,  32'h0,       32'h0,       32'h0,       IDLE});
    vecs.push_back('{1,1,0,0, 32'h80, 32'h0,  32'h0,       32'h0,       BUSY,   1,0,1,0, 32'h80, 32'h0,       32'h0,       32'h0,       IGNT});
    vecs.push_back('{1,0,0,0, 32'h80, 32'h0,  32'h0,       32'h0,       BUSY,   0,0,0,0, 32'h0,  32'h0,       32'h0,       32'h0,       IGNT});
    vecs.push_back('{1,0,0,1, 32'h0,  32'h300,32'h11112222,32'h0,       FREE,   0,1,0,0, 32'h0,  32'h0,       32'h0,       32'h0,       IDLE});
    vecs.push_back('{1,0,0,1, 32'h0,  32'h300,32'h11112222,32'h0,       BUSY,   0,1,0,1, 32'h300,32'h11112222,32'h0,       32'h0,       DGNT});
    vecs.push_back('{0,0,0,1, 32'h0,  32'h300,32'h11112222,32'h0,       BUSY,   0,1,0,1, 32'h300,32'h11112222,32'h0,       32'h0,       DGNT});
    vecs.push_back('{1,0,0,0, 32'h0,  32'h0,  32'h0,       32'h0,       FREE,   0,0,0,0, 32'h0,  32'h0,       32'h0,       32'h0,       IDLE});
    // dREN and dWEN together behave as a store with no load data.
    vecs.push_back('{1,0,1,1, 32'h0,  32'h104,32'h0F0F0F0F,32'h0,       FREE,   0,1,0,0, 32'h0,  32'h0,       32'h0,       32'h0,       IDLE});
    vecs.push_back('{1,0,1,1, 32'h0,  32'h104,32'h0F0F0F0F,32'h99,      ACCESS, 0,0,0,1, 32'h104,32'h0F0F0F0F,32'h0,       32'h0,       DGNT});
    vecs.push_back('{1,0,0,0, 32'h0,  32'h0,  32'h0,       32'h0,       FREE,   0,0,0,0, 32'h0,  32'h0,       32'h0,       32'h0,       IDLE});

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, FREE);
    @(posedge CLK); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].nrst, vecs[i].iren, vecs[i].dren, vecs[i].dwen, vecs[i].iaddr,
                    vecs[i].daddr, vecs[i].dstore, vecs[i].ramload, vecs[i].rs);
      #4;
      checkOutput("state",    i, 32'(dut.state_q), 32'(vecs[i].e_state));
      checkOutput("iwait",    i, 32'(iwait),       32'(vecs[i].e_iwait));
      checkOutput("dwait",    i, 32'(dwait),       32'(vecs[i].e_dwait));
      checkOutput("ramREN",   i, 32'(ramREN),      32'(vecs[i].e_ramren));
      checkOutput("ramWEN",   i, 32'(ramWEN),      32'(vecs[i].e_ramwen));
      checkOutput("ramaddr",  i, ramaddr,          vecs[i].e_ramaddr);
      checkOutput("ramstore", i, ramstore,         vecs[i].e_ramstore);
      checkOutput("iload",    i, iload,            vecs[i].e_iload);
      checkOutput("dload",    i, dload,            vecs[i].e_dload);
      @(posedge CLK); #1;
    end

    // Starvation: iREN held while a load is re-requested in every IDLE cycle.
    checkOutput("starve_start", 100, 32'(dut.starve_cnt_q), 32'd0);
    for (int g = 0; g < 4; g++) begin
      applyStimulus(1, 1, 1, 0, 32'h500, 32'h600 + 32'(4 * g), 0, 0, FREE);
      #4;
      checkOutput("starve_idle_ramREN", 110 + g, 32'(ramREN), 32'd0);
      checkOutput("starve_idle_dwait",  110 + g, 32'(dwait),  32'd1);
      @(posedge CLK); #1;
      applyStimulus(1, 1, 1, 0, 32'h500, 32'h600 + 32'(4 * g), 0, 32'h7000 + 32'(g), ACCESS);
      #4;
      checkOutput("starve_dgnt_ramaddr", 120 + g, ramaddr, 32'h600 + 32'(4 * g));
      checkOutput("starve_dgnt_dwait",   120 + g, 32'(dwait), 32'd0);
      checkOutput("starve_dgnt_dload",   120 + g, dload, 32'h7000 + 32'(g));
      checkOutput("starve_dgnt_iwait",   120 + g, 32'(iwait), 32'd1);
      checkOutput("starve_cnt",          120 + g, 32'(dut.starve_cnt_q), 32'(g + 1));
      @(posedge CLK); #1;
    end
    applyStimulus(1, 1, 1, 0, 32'h500, 32'h700, 0, 0, FREE);
    #4;
    checkOutput("starve_5th_idle_dwait", 130, 32'(dwait), 32'd1);
    @(posedge CLK); #1;
    applyStimulus(1, 1, 1, 0, 32'h500, 32'h700, 0, 32'h8C000000, ACCESS);
    #4;
    checkOutput("starve_5th_ramaddr", 131, ramaddr, 32'h500);
    checkOutput("starve_5th_ramREN",  131, 32'(ramREN), 32'd1);
    checkOutput("starve_5th_iwait",   131, 32'(iwait), 32'd0);
    checkOutput("starve_5th_iload",   131, iload, 32'h8C000000);
    checkOutput("starve_5th_dwait",   131, 32'(dwait), 32'd1);
    checkOutput("starve_5th_cnt",     131, 32'(dut.starve_cnt_q), 32'd0);
    @(posedge CLK); #1;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, FREE);
    #4;
    checkOutput("starve_end_state", 132, 32'(dut.state_q), 32'(IDLE));
    @(posedge CLK); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
